// File: rtl/tick_scheduler.sv
// Four-channel millisecond scheduler sharing one prescaled timebase.
// Optional macro TICK_SCHED_PERIODIC_EN: channels reload on expiry and stay armed until cancelled.
//
// state    | meaning
// CH_IDLE  | channel free, accepts a load request, busy=0
// CH_ARMED | counting down on each tick_1ms, busy=1
module tick_scheduler #(
    parameter int unsigned CLK_DIV = 50_000,
    parameter int unsigned DUR_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             req_valid,
    input  logic [1:0]       req_ch,
    input  logic [DUR_W-1:0] req_dur,
    output logic             req_ready,
    input  logic             cancel,
    input  logic [1:0]       cancel_ch,
    output logic [3:0]       busy,
    output logic [3:0]       done,
    output logic             tick_1ms
);

    localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic {
        CH_IDLE  = 1'b0,
        CH_ARMED = 1'b1
    } ch_state_t;

    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic [3:0]    w_busy;
    logic [3:0]    w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else if (run) begin
            if (r_presc == PRESC_MAX) begin
                r_presc <= '0;
                r_tick  <= 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
                r_tick  <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_ch
        ch_state_t        r_state;
        logic [DUR_W-1:0] r_cnt;
        logic             r_done;
        logic             w_cancel_hit;
        logic             w_accept;
`ifdef TICK_SCHED_PERIODIC_EN
        logic [DUR_W-1:0] r_reload;
`endif

        // A cancel aimed at this channel discards a coincident request even when idle.
        assign w_cancel_hit = cancel && (cancel_ch == 2'(g));
        assign w_accept     = req_valid && (req_ch == 2'(g)) && (r_state == CH_IDLE) && !w_cancel_hit;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state  <= CH_IDLE;
                r_cnt    <= '0;
                r_done   <= 1'b0;
`ifdef TICK_SCHED_PERIODIC_EN
                r_reload <= '0;
`endif
            end else begin
                r_done <= 1'b0;
                case (r_state)
                    CH_IDLE: begin
                        if (w_accept) begin
                            if (req_dur == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state  <= CH_ARMED;
                                r_cnt    <= req_dur;
`ifdef TICK_SCHED_PERIODIC_EN
                                r_reload <= req_dur;
`endif
                            end
                        end
                    end
                    CH_ARMED: begin
                        if (w_cancel_hit) begin
                            r_state <= CH_IDLE;
                            r_cnt   <= '0;
                        end else if (r_tick) begin
                            // Terminal count at 1 so the counter can never wrap below zero.
                            if (r_cnt <= DUR_W'(1)) begin
                                r_done <= 1'b1;
`ifdef TICK_SCHED_PERIODIC_EN
                                r_cnt  <= r_reload;
`else
                                r_state <= CH_IDLE;
                                r_cnt   <= '0;
`endif
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= CH_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        assign w_busy[g] = (r_state == CH_ARMED);
        assign w_done[g] = r_done;
    end

    assign busy      = w_busy;
    assign done      = w_done;
    assign tick_1ms  = r_tick;
    assign req_ready = !w_busy[req_ch];

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter CLK_DIV, default 50_000, clk cycles per 1 ms tick (50 MHz clk); legal range 2..2^20.
REQ-002 Parameter DUR_W, default 16, width of per-channel duration in ms.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  high = timebase advances; low = prescaler and all channel counters frozen.
REQ-006 req_valid  input  1  load request strobe.
REQ-007 req_ch  input  2  target channel 0..3.
REQ-008 req_dur  input  DUR_W  duration in ticks (ms).
REQ-009 req_ready  output  1  combinational; high when the req_ch channel is idle.
REQ-010 cancel  input  1  cancel strobe.
REQ-011 cancel_ch  input  2  channel to cancel.
REQ-012 busy  output  4  per-channel armed flag, registered.
REQ-013 done  output  4  per-channel one-cycle expiry pulse, registered.
REQ-014 tick_1ms  output  1  one-cycle pulse per timebase tick, registered.

Function
REQ-015 Prescaler counts 0..CLK_DIV-1 while run=1, wraps to 0; tick_1ms high for exactly the cycle after the counter equals CLK_DIV-1 at a rising edge.
REQ-016 Four channels share the single prescaler; each holds state IDLE or ARMED and a DUR_W down-counter.
REQ-017 Request accepted in a cycle where req_valid=1 and req_ready=1; req_valid with req_ready=0 is ignored, no state change.
REQ-018 Accept with req_dur=D>0: channel -> ARMED, counter=D, busy bit set next cycle.
REQ-019 Accept with req_dur=0: channel stays IDLE, done bit pulses the next cycle, busy never set.
REQ-020 ARMED counter decrements by 1 on each tick_1ms cycle; first tick counted is the first tick_1ms strictly after the accept cycle.
REQ-021 Counter decrementing from 1 to 0: channel -> IDLE, busy cleared and done pulsed in the same next cycle; done therefore rises exactly D ticks after accept.
REQ-022 Multiple channels expiring on the same tick pulse their done bits simultaneously.
REQ-023 cancel on an ARMED channel: -> IDLE next cycle, busy cleared, no done pulse; cancel on IDLE channel has no effect.
REQ-024 cancel and accept on the same channel in the same cycle: cancel wins, request discarded.
REQ-025 Cancel on a channel in the cycle it would expire: cancel wins, no done pulse.
REQ-026 run=0: tick_1ms held low, prescaler and counters hold; requests and cancels still processed; run=1 resumes from held values.
REQ-027 Counter arithmetic never underflows; no wrap below 0.

Reset
REQ-028 rst_n low asynchronously clears prescaler, all counters, all channels to IDLE, busy=0, done=0, tick_1ms=0.
REQ-029 Reset asserted mid-count discards pending expiries; no done pulse is produced on reset release.
REQ-030 First tick after reset release occurs CLK_DIV cycles after release with run=1.

Configuration
REQ-031 Macro TICK_SCHED_PERIODIC_EN defined: each channel stores its reload value; on expiry it pulses done and reloads to the stored D, staying ARMED (busy stays 1) until cancelled; req_dur=0 behaves as in REQ-019.
REQ-032 Macro undefined: one-shot behaviour only (REQ-021), no reload storage synthesized.

Verification (CLK_DIV=4 for simulation)
REQ-033 run=1, load ch0 D=3 -> done[0] pulses once, 3 ticks after accept (12 clk cycles nominal), busy[0] falls the same cycle.
REQ-034 Load ch1 D=2 and ch2 D=2 on consecutive cycles before a tick -> done[1], done[2] pulse on the same cycle.
REQ-035 Load ch3 D=5, drop run for 20 cycles after 2 ticks, restore -> done[3] delayed by exactly 20 cycles; tick_1ms low during pause.
REQ-036 Load ch0 D=4, cancel ch0 after 1 tick -> busy[0]=0 next cycle, no done[0]; same-cycle cancel+request on ch1 -> ch1 stays IDLE.
REQ-037 Request ch2 while busy[2]=1 -> req_ready=0, counter unchanged; req_dur=0 on ch3 -> done[3] next cycle, busy[3]=0 throughout.
REQ-038 rst_n pulsed low mid-count -> all outputs 0 immediately, no done after release; with TICK_SCHED_PERIODIC_EN, ch0 D=2 -> done[0] every 2 ticks until cancel.
